gcd_scheduler: RTL

GCD_SCHEDULER -- requirements
Module: gcd_scheduler

---
 rtl/gcd_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gcd_scheduler.sv
// GCD request scheduler: queues tagged operand pairs, issues them one at a time
// to an external GCD core and returns each result with the core's cycle count.
module gcd_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       core_start,
  output logic [31:0]                core_a,
  output logic [31:0]                core_b,
  input  logic [31:0]                core_result,
  input  logic                       core_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic [15:0]                out_cycles,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  state_t           state_q, state_d;
  req_t             mem [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [TAG_W-1:0] tag_q;
  logic [15:0]      cyc_q;
  logic             push, pop;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign in_ready = reset && (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ISSUE);
  assign head     = mem[rd_ptr];
  assign count    = count_q;
  assign busy     = (state_q != IDLE) || (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, tag: in_tag};
    end
  end

  // Queue pointers and occupancy; a push and a pop in one cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_done) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Core command is loaded on entry to ISSUE so start is high for that cycle only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      tag_q      <= '0;
    end else begin
      core_start <= (state_d == ISSUE);
      if (state_d == ISSUE) begin
        core_a <= head.a;
        core_b <= head.b;
        tag_q  <= head.tag;
      end
    end
  end

  // Cycle counter and response capture; core_done is only honoured in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_cycles <= '0;
    end else begin
      if (state_q == ISSUE) begin
        cyc_q <= '0;
      end else if ((state_q == WAIT) && !core_done && (cyc_q != 16'hFFFF)) begin
        cyc_q <= cyc_q + 16'd1;
      end
      if ((state_q == WAIT) && core_done) begin
        out_result <= core_result;
        out_tag    <= tag_q;
        out_cycles <= cyc_q;
      end
      out_valid <= (state_d == HOLD);
    end
  end

endmodule
